// File: rtl/fwd_pkg.sv
// ============================================================================
// Module   : fwd_pkg
// Brief    : Forwarding-select constants, shadow-stage type and match helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fwd_pkg;

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_ALU = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    localparam logic [3:0] REG_PC  = 4'd15;

    typedef struct packed {
        logic       valid;
        logic [3:0] dest;
        logic       wb_en;
        logic       mem_r_en;
    } stage_t;

    // The PC is never forwarded; its value comes from the fetch path.
    function automatic logic src_match(input stage_t s, input logic [3:0] src);
        return s.valid && s.wb_en && (s.dest == src) && (src != REG_PC);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_stage_reg.sv
// ============================================================================
// Module   : fwd_stage_reg
// Brief    : One shadow pipeline-stage register with freeze hold and valid clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_stage_reg
    import fwd_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_freeze,
    input  logic   i_clr,
    input  stage_t i_d,
    output stage_t o_q
);

    stage_t r_q;
    stage_t w_d;

    always_comb begin
        w_d       = i_d;
        w_d.valid = i_d.valid & ~i_clr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (!i_freeze) begin
            r_q <= w_d;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/fwd_sel_ctrl.sv
// ============================================================================
// Module   : fwd_sel_ctrl
// Brief    : EXE forwarding-select and load-use hazard control.
//            Macro FWD_EN enables forwarding; without it every match stalls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_sel_ctrl
    import fwd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ID_valid,
    input  logic [3:0] ID_src1,
    input  logic [3:0] ID_src2,
    input  logic       ID_two_src,
    input  logic [3:0] ID_dest,
    input  logic       ID_WB_EN,
    input  logic       ID_MEM_R_EN,
    input  logic       freeze,
    input  logic       flush,
    output logic [1:0] Sel_src1,
    output logic [1:0] Sel_src2,
    output logic       hazard
);

    stage_t w_id_stage;
    stage_t r_exe;
    stage_t r_mem;
    logic   w_bubble;
    logic   w_m1_exe;
    logic   w_m1_mem;
    logic   w_m2_exe;
    logic   w_m2_mem;
    logic   w_unused;

    assign w_id_stage = '{valid: ID_valid, dest: ID_dest, wb_en: ID_WB_EN, mem_r_en: ID_MEM_R_EN};

    assign w_m1_exe = src_match(r_exe, ID_src1);
    assign w_m1_mem = src_match(r_mem, ID_src1);
    assign w_m2_exe = ID_two_src & src_match(r_exe, ID_src2);
    assign w_m2_mem = ID_two_src & src_match(r_mem, ID_src2);

    assign w_bubble = hazard | flush;

    fwd_stage_reg u_exe_stage (
        .clk      (clk),
        .rst      (rst),
        .i_freeze (freeze),
        .i_clr    (w_bubble),
        .i_d      (w_id_stage),
        .o_q      (r_exe)
    );

    fwd_stage_reg u_mem_stage (
        .clk      (clk),
        .rst      (rst),
        .i_freeze (freeze),
        .i_clr    (1'b0),
        .i_d      (r_exe),
        .o_q      (r_mem)
    );

`ifdef FWD_EN
    logic       w_exe_load;
    logic [1:0] w_sel1_nxt;
    logic [1:0] w_sel2_nxt;
    logic [1:0] r_sel1;
    logic [1:0] r_sel2;

    // Only a load in EXE cannot be forwarded in time; everything else bypasses.
    assign w_exe_load = r_exe.valid & r_exe.mem_r_en & r_exe.wb_en;
    assign hazard     = ID_valid & ~flush & w_exe_load & (w_m1_exe | w_m2_exe);

    always_comb begin
        w_sel1_nxt = SEL_REG;
        w_sel2_nxt = SEL_REG;
        if (w_m1_exe)      w_sel1_nxt = SEL_ALU;
        else if (w_m1_mem) w_sel1_nxt = SEL_WB;
        if (w_m2_exe)      w_sel2_nxt = SEL_ALU;
        else if (w_m2_mem) w_sel2_nxt = SEL_WB;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel1 <= SEL_REG;
            r_sel2 <= SEL_REG;
        end else if (!freeze) begin
            r_sel1 <= w_bubble ? SEL_REG : w_sel1_nxt;
            r_sel2 <= w_bubble ? SEL_REG : w_sel2_nxt;
        end
    end

    assign Sel_src1 = r_sel1;
    assign Sel_src2 = r_sel2;
`else
    assign hazard   = ID_valid & ~flush & (w_m1_exe | w_m1_mem | w_m2_exe | w_m2_mem);
    assign Sel_src1 = SEL_REG;
    assign Sel_src2 = SEL_REG;
`endif

    assign w_unused = ^{r_exe.mem_r_en, r_mem.mem_r_en};

endmodule

`default_nettype wire

// File: tb/tb_fwd_sel_ctrl.sv
// ============================================================================
// Module   : tb_fwd_sel_ctrl
// Brief    : Directed bench for fwd_sel_ctrl (expectations follow FWD_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fwd_sel_ctrl;

`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ID_valid;
    logic [3:0] ID_src1;
    logic [3:0] ID_src2;
    logic       ID_two_src;
    logic [3:0] ID_dest;
    logic       ID_WB_EN;
    logic       ID_MEM_R_EN;
    logic       freeze;
    logic       flush;
    logic [1:0] Sel_src1;
    logic [1:0] Sel_src2;
    logic       hazard;

    int n_checks = 0;
    int n_errors = 0;

    fwd_sel_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ID_valid    (ID_valid),
        .ID_src1     (ID_src1),
        .ID_src2     (ID_src2),
        .ID_two_src  (ID_two_src),
        .ID_dest     (ID_dest),
        .ID_WB_EN    (ID_WB_EN),
        .ID_MEM_R_EN (ID_MEM_R_EN),
        .freeze      (freeze),
        .flush       (flush),
        .Sel_src1    (Sel_src1),
        .Sel_src2    (Sel_src2),
        .hazard      (hazard)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                          input logic two, input logic [3:0] d, input logic wb, input logic mr);
        ID_valid    = v;
        ID_src1     = s1;
        ID_src2     = s2;
        ID_two_src  = two;
        ID_dest     = d;
        ID_WB_EN    = wb;
        ID_MEM_R_EN = mr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        freeze = 1'b0;
        flush  = 1'b0;
        set_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    initial begin
        rst    = 1'b1;
        freeze = 1'b0;
        flush  = 1'b0;
        set_id(1'b1, 4'd1, 4'd1, 1'b1, 4'd1, 1'b1, 1'b0);
        repeat (2) tick();
        check("rst_sel1", Sel_src1, 2'b00);
        check("rst_sel2", Sel_src2, 2'b00);
        check("rst_haz", {1'b0, hazard}, 2'b00);
        rst = 1'b0;
        drain();

        // ADD R1 ; SUB src1=R1
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
        check("add_haz", {1'b0, hazard}, 2'b00);
        tick();
        set_id(1'b1, 4'd1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
        check("raw_exe_haz", {1'b0, hazard}, FWD ? 2'b00 : 2'b01);
        tick();
        check("raw_exe_sel1", Sel_src1, FWD ? 2'b01 : 2'b00);
        // freeze must hold a non-zero select
        freeze = 1'b1;
        set_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (2) tick();
        check("frz_hold_sel1", Sel_src1, FWD ? 2'b01 : 2'b00);
        drain();

        // ADD R2 ; unrelated ; ORR src2=R2 (two_src=1, then two_src=0)
        for (int k = 0; k < 2; k++) begin
            set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);
            tick();
            set_id(1'b1, 4'd8, 4'd9, 1'b1, 4'd10, 1'b1, 1'b0);
            check("unrel_haz", {1'b0, hazard}, 2'b00);
            tick();
            set_id(1'b1, 4'd11, 4'd2, (k == 0), 4'd12, 1'b1, 1'b0);
            check("mem_fwd_haz", {1'b0, hazard}, (FWD || k == 1) ? 2'b00 : 2'b01);
            tick();
            check("mem_fwd_sel2", Sel_src2, (FWD && k == 0) ? 2'b10 : 2'b00);
            drain();
        end

        // LDR R3 ; ADD src1=R3 -> one-cycle load-use stall
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 4'd3, 4'd0, 1'b0, 4'd13, 1'b1, 1'b0);
        check("ld_use_haz", {1'b0, hazard}, 2'b01);
        tick();
        check("ld_use_bubble", Sel_src1, 2'b00);
        check("ld_use_haz2", {1'b0, hazard}, FWD ? 2'b00 : 2'b01);
        tick();
        check("ld_use_sel1", Sel_src1, FWD ? 2'b10 : 2'b00);
        check("ld_use_haz3", {1'b0, hazard}, 2'b00);
        drain();

        // ADD R15 ; reader of R15
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 4'd15, 4'd15, 1'b1, 4'd1, 1'b1, 1'b0);
        check("pc_haz", {1'b0, hazard}, 2'b00);
        tick();
        check("pc_sel1", Sel_src1, 2'b00);
        check("pc_sel2", Sel_src2, 2'b00);
        drain();

        // ADD R4 ; ADD R4 ; reader of R4 -> EXE priority
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
        tick();
        tick();
        set_id(1'b1, 4'd4, 4'd4, 1'b1, 4'd9, 1'b1, 1'b0);
        check("prio_haz", {1'b0, hazard}, FWD ? 2'b00 : 2'b01);
        tick();
        check("prio_sel1", Sel_src1, FWD ? 2'b01 : 2'b00);
        check("prio_sel2", Sel_src2, FWD ? 2'b01 : 2'b00);
        drain();

        // LDR R5 ; dependent with flush
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);
        tick();
        flush = 1'b1;
        set_id(1'b1, 4'd5, 4'd0, 1'b0, 4'd14, 1'b1, 1'b0);
        check("flush_haz", {1'b0, hazard}, 2'b00);
        tick();
        flush = 1'b0;
        check("flush_sel1", Sel_src1, 2'b00);
        set_id(1'b1, 4'd14, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
        check("flush_squash_haz", {1'b0, hazard}, 2'b00);
        tick();
        check("flush_squash_sel1", Sel_src1, 2'b00);
        drain();

        // LDR R5 ; dependent held by freeze for 3 cycles
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 4'd5, 4'd0, 1'b0, 4'd14, 1'b1, 1'b0);
        freeze = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("frz_haz", {1'b0, hazard}, 2'b01);
            check("frz_sel1", Sel_src1, 2'b00);
        end
        freeze = 1'b0;
        tick();
        check("frz_bubble", Sel_src1, 2'b00);
        check("frz_haz2", {1'b0, hazard}, FWD ? 2'b00 : 2'b01);
        tick();
        check("frz_resume_sel1", Sel_src1, FWD ? 2'b10 : 2'b00);
        drain();

        // ADD R6 ; reader of R6 -> two-cycle stall without forwarding
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 4'd6, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        check("nofwd_haz1", {1'b0, hazard}, FWD ? 2'b00 : 2'b01);
        tick();
        check("nofwd_sel1", Sel_src1, FWD ? 2'b01 : 2'b00);
        check("nofwd_haz2", {1'b0, hazard}, FWD ? 2'b00 : 2'b01);
        tick();
        check("nofwd_haz3", {1'b0, hazard}, 2'b00);
        drain();

        // reset pulse during a stall
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 4'd1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 4'd3, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0);
        check("pre_rst_sel1", Sel_src1, FWD ? 2'b01 : 2'b00);
        check("pre_rst_haz", {1'b0, hazard}, FWD ? 2'b01 : 2'b00);
        rst = 1'b1;
        #1;
        check("mid_rst_haz", {1'b0, hazard}, 2'b00);
        check("mid_rst_sel1", Sel_src1, 2'b00);
        check("mid_rst_sel2", Sel_src2, 2'b00);
        #2;
        rst = 1'b0;
        #1;
        check("post_rst_haz", {1'b0, hazard}, 2'b00);
        tick();
        check("post_rst_sel1", Sel_src1, 2'b00);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fwd_sel_ctrl.md
FWD_SEL_CTRL -- requirements
Module: fwd_sel_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset:
  - clk  in  1  rising-edge clock
  - rst  in  1  async active-high reset
REQ-002 The block SHALL have these inputs:
  - ID_valid  in  1  ID-stage instruction present
  - ID_src1  in  4  Rn of ID instruction
  - ID_src2  in  4  Rm/Rd of ID instruction
  - ID_two_src  in  1  ID instruction reads src2
  - ID_dest  in  4  destination of ID instruction
  - ID_WB_EN  in  1  ID instruction writes the register file
  - ID_MEM_R_EN  in  1  ID instruction is a load
  - freeze  in  1  global pipeline hold (memory stall)
  - flush  in  1  taken branch; squash ID instruction
REQ-003 The block SHALL have these outputs:
  - Sel_src1  out  2  EXE src1 forwarding select, registered
  - Sel_src2  out  2  EXE src2 forwarding select, registered
  - hazard  out  1  stall IF/ID and insert an EXE bubble, combinational

Function
REQ-004 Select encoding SHALL be: 00 = register value, 01 = MEM-stage ALU result, 10 = WB value; 11 is never driven.
REQ-005 The block SHALL keep two shadow stage registers, EXE and MEM. Each holds {valid, dest, WB_EN, MEM_R_EN}.
REQ-006 On each rising edge with freeze=0, MEM shadow SHALL load EXE shadow. EXE shadow SHALL load the ID fields, with valid = ID_valid & ~hazard & ~flush.
REQ-007 A source "matches" a shadow stage iff stage valid & WB_EN & dest == src & src != 4'd15.
REQ-008 src2 matching SHALL only apply when ID_two_src=1; otherwise the next Sel_src2 is 00.
REQ-009 Next Sel for each source SHALL be 01 if it matches the EXE shadow, else 10 if it matches the MEM shadow, else 00. The EXE match has priority.
REQ-010 Sel_src1/Sel_src2 SHALL register at the same edge that EXE shadow loads. They become 00 when hazard=1 or flush=1 (bubble).
REQ-011 hazard SHALL be 1 iff ID_valid & ~flush & EXE shadow is a load (valid & MEM_R_EN & WB_EN) matching ID_src1, or matching ID_src2 with ID_two_src=1.
REQ-012 A load-use stall SHALL last exactly one cycle. On the next cycle the load sits in MEM shadow and the dependent source selects 10.
REQ-013 With freeze=1, all registers SHALL hold, and hazard SHALL still be evaluated combinationally.
REQ-014 flush and hazard together: flush SHALL win, so hazard=0 and a bubble is inserted.

Reset
REQ-015 rst=1 SHALL asynchronously clear both shadow valids, Sel_src1=00 and Sel_src2=00. hazard therefore reads 0.
REQ-016 Reset asserted mid-stall SHALL abandon the stall. After release, the first ID instruction SHALL see no in-flight producers.

Configuration
REQ-017 Macro FWD_EN controls forwarding:
  - Defined: behaviour is as in REQ-009 to REQ-012.
  - Undefined: Sel_src1/Sel_src2 SHALL be constant 00. hazard SHALL assert on any match (REQ-007) against either the EXE or the MEM shadow, regardless of MEM_R_EN.

Structure
REQ-018 Package fwd_pkg SHALL hold:
  - the select constants SEL_REG, SEL_ALU, SEL_WB
  - REG_PC = 4'd15
  - the shadow-stage struct typedef
REQ-019 One sub-module, fwd_stage_reg, SHALL implement a shadow stage register with async reset, freeze hold and valid-clear. It SHALL be instantiated twice.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
  - ADD R1 (WB_EN) then SUB reading src1=R1, back-to-back -> next-edge Sel_src1=01, hazard=0.
  - ADD R2, unrelated instruction, then ORR with src2=R2 and two_src=1 -> Sel_src2=10. The same sequence with two_src=0 -> Sel_src2=00.
  - LDR R3 then ADD src1=R3 -> hazard=1 for one cycle, Sel_src1=00 (bubble), then Sel_src1=10 and hazard=0.
  - ADD R15 then a reader of R15 -> Sel=00. ADD R4 then ADD R4 then a reader of R4 -> Sel=01 (EXE priority).
  - LDR R5 with dependent in ID, with flush=1 and freeze=1 applied in separate runs -> flush gives hazard=0 and bubble. freeze holds Sel and shadows for 3 cycles, then resumes identically.
  - Build without FWD_EN: ADD R6 then a reader of R6 -> hazard=1 for two cycles, Sel always 00. A reset pulse during a stall -> outputs are 00/0 immediately.
